// File: rtl/fft_dma_reader.sv
// fft_dma_reader: drains an FFT result frame over the DMA read port
// and forwards the bins as a valid/ready stream with the frame exponent.
module fft_dma_reader #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int FFT_N      = $clog2(FFT_LENGTH),
    parameter int OUT_BINS   = FFT_LENGTH / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    input  logic [7:0]        bfpexp,
    output logic              fin,
    output logic              dmaact,
    output logic [FFT_N-1:0]  dmaa,
    input  logic [FFT_DW-1:0] dmadr_real,
    input  logic [FFT_DW-1:0] dmadr_imag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FFT_N-1:0]  m_index,
    output logic [FFT_DW-1:0] m_real,
    output logic [FFT_DW-1:0] m_imag,
    output logic [7:0]        m_exp,
    output logic              m_last,
    output logic              busy,
    output logic              abort
);

    localparam int CW = FFT_N + 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_BINS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FIN,
        WAIT_LOW
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     issue_addr;
    logic              issue;
    logic              rvalid;
    logic [FFT_N-1:0]  ridx;

    logic [FFT_N-1:0]  f_idx [2];
    logic [FFT_DW-1:0] f_re  [2];
    logic [FFT_DW-1:0] f_im  [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt, cnt_next;
    logic              pop, push_store, pop_store, credit_ok, stored;

    // Head of the stream: stored entries first, else the beat landing now.
    assign stored  = (cnt != 2'd0);
    assign m_valid = stored || rvalid;
    assign m_index = stored ? f_idx[rd_ptr] : (rvalid ? ridx : '0);
    assign m_real  = stored ? f_re[rd_ptr] : (rvalid ? dmadr_real : '0);
    assign m_imag  = stored ? f_im[rd_ptr] : (rvalid ? dmadr_imag : '0);
    assign m_last  = m_valid && (m_index == LAST[FFT_N-1:0]);

    assign fin   = (state_q == FIN);
    assign busy  = (state_q != IDLE);
    assign abort = ((state_q == READ) || (state_q == DRAIN)) && !done;

    assign pop        = m_valid && m_ready && !abort;
    assign push_store = rvalid && !(!stored && pop);
    assign pop_store  = pop && stored;
    assign cnt_next   = cnt + {1'b0, push_store} - {1'b0, pop_store};
    assign credit_ok  = ({1'b0, cnt_next} + {2'b00, dmaact}) < 3'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = rd_cnt;
        unique case (state_q)
            IDLE: begin
                if (done) begin
                    issue      = 1'b1;
                    issue_addr = '0;
                    state_d    = (LAST == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (!done) begin
                    state_d = IDLE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_cnt == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!done) begin
                    state_d = IDLE;
                end else if (cnt_next == 2'd0 && !dmaact) begin
                    state_d = FIN;
                end
            end
            FIN: state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmaact <= 1'b0;
            dmaa   <= '0;
            rd_cnt <= '0;
            m_exp  <= '0;
            ridx   <= '0;
            rvalid <= 1'b0;
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            dmaact <= issue;
            if (issue) begin
                dmaa   <= issue_addr[FFT_N-1:0];
                rd_cnt <= issue_addr + CW'(1);
            end
            if (state_q == IDLE && done) m_exp <= bfpexp;
            ridx <= dmaa;
            // Abort drops buffered beats and the read still in flight.
            if (abort) begin
                rvalid <= 1'b0;
                cnt    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                rvalid <= dmaact;
                cnt    <= cnt_next;
                if (push_store) wr_ptr <= ~wr_ptr;
                if (pop_store)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_store && !abort) begin
            f_idx[wr_ptr] <= ridx;
            f_re[wr_ptr]  <= dmadr_real;
            f_im[wr_ptr]  <= dmadr_imag;
        end
    end

endmodule

// File: tb/tb_fft_dma_reader.sv
// Directed and randomized bench for fft_dma_reader: three builds
// (OUT_BINS 8, 1, 16) share a clock and a behavioural frame memory.
module tb_fft_dma_reader;

    localparam int L  = 16;
    localparam int DW = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          done    [3];
    logic          m_ready [3];
    logic [7:0]    bfpexp  [3];
    logic          dmaact  [3];
    logic          fin     [3];
    logic          m_valid [3];
    logic          m_last  [3];
    logic          busy    [3];
    logic          abort   [3];
    logic [7:0]    m_exp   [3];
    logic [N-1:0]  dmaa    [3];
    logic [N-1:0]  m_index [3];
    logic [DW-1:0] rd_re   [3];
    logic [DW-1:0] rd_im   [3];
    logic [DW-1:0] m_real  [3];
    logic [DW-1:0] m_imag  [3];

    logic [DW-1:0] mem_re [L];
    logic [DW-1:0] mem_im [L];

    int total = 0;
    int bad   = 0;

    fft_dma_reader #(.FFT_LENGTH(L), .FFT_DW(DW), .OUT_BINS(8)) u0 (
        .clk(clk), .rst_n(rst_n), .done(done[0]), .bfpexp(bfpexp[0]),
        .fin(fin[0]), .dmaact(dmaact[0]), .dmaa(dmaa[0]),
        .dmadr_real(rd_re[0]), .dmadr_imag(rd_im[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_index(m_index[0]),
        .m_real(m_real[0]), .m_imag(m_imag[0]), .m_exp(m_exp[0]),
        .m_last(m_last[0]), .busy(busy[0]), .abort(abort[0])
    );

    fft_dma_reader #(.FFT_LENGTH(L), .FFT_DW(DW), .OUT_BINS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .done(done[1]), .bfpexp(bfpexp[1]),
        .fin(fin[1]), .dmaact(dmaact[1]), .dmaa(dmaa[1]),
        .dmadr_real(rd_re[1]), .dmadr_imag(rd_im[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_index(m_index[1]),
        .m_real(m_real[1]), .m_imag(m_imag[1]), .m_exp(m_exp[1]),
        .m_last(m_last[1]), .busy(busy[1]), .abort(abort[1])
    );

    fft_dma_reader #(.FFT_LENGTH(L), .FFT_DW(DW), .OUT_BINS(16)) u2 (
        .clk(clk), .rst_n(rst_n), .done(done[2]), .bfpexp(bfpexp[2]),
        .fin(fin[2]), .dmaact(dmaact[2]), .dmaa(dmaa[2]),
        .dmadr_real(rd_re[2]), .dmadr_imag(rd_im[2]),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_index(m_index[2]),
        .m_real(m_real[2]), .m_imag(m_imag[2]), .m_exp(m_exp[2]),
        .m_last(m_last[2]), .busy(busy[2]), .abort(abort[2])
    );

    // Core result memory: one-cycle read latency.
    always_ff @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (dmaact[u]) begin
                rd_re[u] <= mem_re[dmaa[u]];
                rd_im[u] <= mem_im[dmaa[u]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pay(input int u);
        return {19'd0, m_index[u], m_real[u], m_imag[u], m_exp[u], m_last[u]};
    endfunction

    function automatic logic [63:0] outs(input int u);
        return {10'd0, fin[u], dmaact[u], dmaa[u], m_valid[u], m_last[u],
                m_index[u], m_real[u], m_imag[u], m_exp[u], busy[u], abort[u]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit rnd);
        for (int k = 0; k < L; k++) begin
            mem_re[k] = rnd ? DW'($urandom) : DW'(100 + k);
            mem_im[k] = rnd ? DW'($urandom) : DW'(-k);
        end
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. cut>=0 drops
    // done once that many beats have been accepted.
    task automatic drain(input int u, input int nb, input logic [7:0] e,
                         input int rmode, input int cut);
        int got, fins, issued, cyc;
        bit pv, cred_ok, addr_ok;
        logic [63:0] held, want;
        got = 0; fins = 0; issued = 0; cyc = 0;
        pv = 0; cred_ok = 1; addr_ok = 1; held = '0;
        bfpexp[u] = e;
        done[u] = 1'b1;
        step();
        bfpexp[u] = 8'($urandom);
        check("lat_act", {dmaact[u], m_valid[u], dmaa[u]}, {1'b1, 1'b0, 4'd0});
        while (got < nb && cyc < 400) begin
            case (rmode)
                0: m_ready[u] = 1'b1;
                1: m_ready[u] = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready[u] = 1'($urandom);
            endcase
            if (cut >= 0 && got == cut) begin
                done[u] = 1'b0;
                #1;
                check("abort_pulse", {abort[u], fin[u]}, 2'b10);
                step();
                check("post_abort",
                      {m_valid[u], busy[u], abort[u], dmaact[u], fin[u]}, '0);
                m_ready[u] = 1'b1;
                return;
            end
            if (cyc == 1)
                check("lat_valid", {m_valid[u], m_index[u]}, {1'b1, 4'd0});
            if (dmaact[u]) begin
                if (dmaa[u] != N'(issued)) addr_ok = 0;
                issued++;
            end
            if (issued - got > 2) cred_ok = 0;
            if (pv) check("stall_hold", {m_valid[u], pay(u)}, {1'b1, held});
            if (m_valid[u] && m_ready[u]) begin
                want = {19'd0, N'(got), mem_re[got], mem_im[got], e,
                        1'(got == nb - 1)};
                check("beat", pay(u), want);
                got++;
            end
            fins += int'(fin[u]);
            pv = m_valid[u] && !m_ready[u];
            held = pay(u);
            step();
            cyc++;
        end
        m_ready[u] = 1'b1;
        check("all_beats", 64'(got), 64'(nb));
        for (int k = 0; k < 5; k++) begin
            fins += int'(fin[u]);
            step();
        end
        check("fin_once", 64'(fins), 64'd1);
        check("wait_low", {busy[u], m_valid[u], dmaact[u]}, 3'b100);
        check("credit", 64'(cred_ok), 64'd1);
        check("addr_seq", 64'(addr_ok), 64'd1);
    endtask

    initial begin
        bit act;
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            done[u] = 1'b0;
            m_ready[u] = 1'b1;
            bfpexp[u] = 8'd0;
        end
        fill(0);
        step();
        check("reset", outs(0), '0);
        rst_n = 1'b1;
        step();

        // fixed memory image, always ready
        drain(0, 8, 8'hFD, 0, -1);
        done[0] = 1'b0;
        step();
        check("idle_after", 64'(busy[0]), 64'd0);

        // backpressure pattern 1,0,0,1
        drain(0, 8, 8'hFD, 1, -1);
        done[0] = 1'b0;
        step();

        // done held high: no second drain, then a fresh frame
        fill(1);
        drain(0, 8, 8'h11, 2, -1);
        act = 0;
        for (int k = 0; k < 20; k++) begin
            if (dmaact[0] || m_valid[0] || fin[0] || !busy[0]) act = 1;
            step();
        end
        check("no_redrain", 64'(act), 64'd0);
        done[0] = 1'b0;
        step();
        check("idle_low", 64'(busy[0]), 64'd0);
        fill(1);
        drain(0, 8, 8'h5A, 2, -1);
        done[0] = 1'b0;
        step();

        // done drops after four beats
        fill(1);
        drain(0, 8, 8'h80, 0, 4);
        step();
        check("abort_idle", {busy[0], fin[0], abort[0]}, 3'b000);

        // asynchronous reset in the middle of a read burst
        bfpexp[0] = 8'h42;
        done[0] = 1'b1;
        m_ready[0] = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(0), '0);
        done[0] = 1'b0;
        m_ready[0] = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        fill(1);
        drain(0, 8, 8'h42, 2, -1);
        done[0] = 1'b0;
        step();

        for (int r = 0; r < 3; r++) begin
            fill(1);
            drain(0, 8, 8'($urandom), 2, -1);
            done[0] = 1'b0;
            step();
        end

        // single-bin and full-frame builds
        fill(1);
        drain(1, 1, 8'hF0, 2, -1);
        done[1] = 1'b0;
        step();
        drain(2, 16, 8'h07, 0, -1);
        done[2] = 1'b0;
        step();
        fill(1);
        drain(2, 16, 8'($urandom), 2, -1);
        done[2] = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_dma_reader.md
Name: fft_dma_reader

Overview:
- Bus master on the FFT core's DMA read port; drains the result frame once the core reports done.
- Reads bins 0..OUT_BINS-1 over dmaact/dmaa/dmadr_*. Bus read latency is one cycle.
- Emits the bins as a valid/ready stream tagged with bin index and the frame's block-floating-point exponent.
- Pulses fin to release the core back to input streaming. Feeds the downstream magnitude/peak-picking stage.

Parameters:
FFT_LENGTH, 1024, frame length, power of two
FFT_DW, 16, data width per real/imag component
FFT_N, $clog2(FFT_LENGTH), address width, derived, never overridden
OUT_BINS, FFT_LENGTH/2, bins drained per frame, range 1..FFT_LENGTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
done  in  1  core status: result frame available (level)
bfpexp  in  8  signed frame exponent, valid while done=1
fin  out  1  one-cycle pulse: frame fully drained
dmaact  out  1  DMA read strobe
dmaa  out  FFT_N  DMA read address
dmadr_real  in  FFT_DW  read data, valid the cycle after dmaact
dmadr_imag  in  FFT_DW  read data, valid the cycle after dmaact
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_index  out  FFT_N  bin index of beat
m_real  out  FFT_DW  signed real part
m_imag  out  FFT_DW  signed imaginary part
m_exp  out  8  latched bfpexp for the frame
m_last  out  1  beat is bin OUT_BINS-1
busy  out  1  high in any state other than IDLE
abort  out  1  one-cycle pulse when done drops mid-frame

Behaviour:
- Reset (async assert, sync deassert): state IDLE, FIFO empty. fin, dmaact, dmaa, m_valid, m_last, m_index, m_real, m_imag, m_exp, busy and abort all reset to 0.
- States: IDLE, READ, DRAIN, FIN, WAIT_LOW.
  - IDLE -> READ when done=1. Latch bfpexp into m_exp. Clear the read address counter.
  - READ: issue reads from a 2-entry output FIFO with credit control.
    - dmaact=1 in a cycle only if (fifo_count + inflight) < 2, where inflight = dmaact of the previous cycle.
    - dmaa = read counter; the counter increments on each issued read.
    - After issuing address OUT_BINS-1 -> DRAIN.
  - DRAIN: no reads. -> FIN when the FIFO is empty, no read is in flight, and the last beat has handshaken.
  - FIN: fin=1 for exactly one cycle -> WAIT_LOW.
  - WAIT_LOW: -> IDLE when done=0. This prevents re-draining the same frame.
- dmaact and dmaa are registered; dmaa holds its last value when dmaact=0.
- Return data is written to the FIFO on the cycle after dmaact=1, together with its index. m_last = (index == OUT_BINS-1).
- Output is the FIFO head: m_valid = FIFO non-empty. A beat transfers when m_valid and m_ready are both high.
- Payload stays stable while m_valid=1 and m_ready=0. No beat is dropped or duplicated.
- Latency: done sampled high at edge t -> dmaact=1, dmaa=0 during t+1 -> m_valid=1 with m_index=0 during t+2.
- Throughput: with m_ready held high, one beat per cycle sustained.
- FIFO handles simultaneous push and pop; count stays unchanged.
- done falls in READ or DRAIN:
  - pulse abort, flush the FIFO, discard any in-flight data, go to IDLE.
  - No fin is issued.
  - A beat presented in the abort cycle is not considered transferred.
- OUT_BINS=1: a single read; the first beat has m_last=1.
- Index arithmetic is unsigned FFT_N bits. OUT_BINS=FFT_LENGTH reads the whole frame with no counter wrap before stopping.
- bfpexp changes after latching are ignored until the next frame.

Test Plan:
1. FFT_LENGTH=16, OUT_BINS=8; done rises with bfpexp=-3, m_ready=1, memory word k = {imag=-k, real=100+k}.
   - Expect m_valid from 2 cycles after done.
   - Expect 8 consecutive beats: index 0..7, real 100..107, imag 0..-7, m_exp=-3, m_last only on index 7.
   - Expect fin pulse exactly once.
2. Same setup with m_ready toggling 1,0,0,1 repeating.
   - Expect all 8 beats in order, payload stable while stalled, never >2 reads outstanding+buffered.
   - Expect dmaact=0 while FIFO full.
3. done held high 20 cycles after fin.
   - Expect no second drain.
   - After done low then high again, expect a new drain starting at index 0 with the new bfpexp.
4. done drops after index 3 is accepted.
   - Expect abort pulse, no fin, m_valid=0 next cycle, state IDLE.
5. rst_n asserted mid-READ.
   - Expect all outputs 0 immediately (async).
   - After release with done=1, expect a clean drain from index 0.
6. OUT_BINS=1 and OUT_BINS=16 builds.
   - Expect 1 beat with m_last=1, and 16 beats 0..15 respectively, each followed by one fin.
